// File: rtl/fp32_result_serializer_if.sv
`default_nettype none
// =============================================================================
// Module      : fp32_result_serializer_if
// Description : Handshake bundle between the FP32 multiplier stage, the
//               result serializer and the downstream byte consumer.
//               The serializer connects through the slave modport; the
//               environment driving products and accepting bytes uses master.
// Revision    : 1.0 - initial release
// =============================================================================
interface fp32_result_serializer_if;
   logic        prod_valid;
   logic [31:0] product;
   logic        prod_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_last;
   logic        busy;
   logic [7:0]  frame_cnt;

   modport slave (
      input  prod_valid, product, byte_ready,
      output prod_ready, byte_out, byte_valid, byte_last, busy, frame_cnt
   );

   modport master (
      output prod_valid, product, byte_ready,
      input  prod_ready, byte_out, byte_valid, byte_last, busy, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fp32_result_serializer.sv
`default_nettype none
// =============================================================================
// Module      : fp32_result_serializer
// Description : Captures one IEEE-754 single-precision product and sends it
//               as a framed byte stream with valid/ready handshaking.
//               Define FP32_SER_CLASS_EN to append a fifth, class byte
//               (zero/inf/NaN/denormal/sign flags) to every frame.
// Revision    : 1.0 - initial release
// =============================================================================
module fp32_result_serializer #(
   parameter int MSB_FIRST = 1
) (
   input  wire logic                clk,
   input  wire logic                reset,
   fp32_result_serializer_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

`ifdef FP32_SER_CLASS_EN
   localparam logic [2:0] c_LAST_IDX = 3'd4;
`else
   localparam logic [2:0] c_LAST_IDX = 3'd3;
`endif

   state_t      r_state;
   logic [31:0] r_word;
   logic [2:0]  r_idx;
   logic        r_prod_ready;
   logic [7:0]  r_byte_out;
   logic        r_byte_valid;
   logic        r_byte_last;
   logic [7:0]  r_frame_cnt;

   logic [2:0]  w_idx_nxt;
   logic [7:0]  w_class;

   assign w_idx_nxt = r_idx + 3'd1;

`ifdef FP32_SER_CLASS_EN
   logic w_exp_zero;
   logic w_exp_ones;
   logic w_mant_nz;

   assign w_exp_zero = (r_word[30:23] == 8'h00);
   assign w_exp_ones = (r_word[30:23] == 8'hFF);
   assign w_mant_nz  = (r_word[22:0] != 23'd0);

   // Class flags of the latched word; constant for the whole frame.
   assign w_class = {3'b000,
                     r_word[31],
                     w_exp_zero &  w_mant_nz,
                     w_exp_ones &  w_mant_nz,
                     w_exp_ones & ~w_mant_nz,
                     w_exp_zero & ~w_mant_nz};
`else
   assign w_class = 8'h00;
`endif

   // Byte presented at a given frame position; position 4 is the class byte,
   // which always trails the four data bytes whatever the byte order.
   function automatic logic [7:0] f_pick(input logic [31:0] word,
                                         input logic [2:0]  idx,
                                         input logic [7:0]  cls);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = (MSB_FIRST != 0) ? word[31:24] : word[7:0];
         3'd1:    b = (MSB_FIRST != 0) ? word[23:16] : word[15:8];
         3'd2:    b = (MSB_FIRST != 0) ? word[15:8]  : word[23:16];
         3'd3:    b = (MSB_FIRST != 0) ? word[7:0]   : word[31:24];
         default: b = cls;
      endcase
      return b;
   endfunction

   // Frame FSM: capture in IDLE, advance one byte per accepted handshake in
   // SEND; all handshake outputs are registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_word       <= 32'd0;
         r_idx        <= 3'd0;
         r_prod_ready <= 1'b0;
         r_byte_out   <= 8'h00;
         r_byte_valid <= 1'b0;
         r_byte_last  <= 1'b0;
         r_frame_cnt  <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_prod_ready && bus.prod_valid) begin
                  r_state      <= ST_SEND;
                  r_word       <= bus.product;
                  r_idx        <= 3'd0;
                  r_prod_ready <= 1'b0;
                  r_byte_valid <= 1'b1;
                  r_byte_out   <= f_pick(bus.product, 3'd0, 8'h00);
                  r_byte_last  <= 1'b0;
               end else begin
                  // Also raises ready on the first edge out of reset.
                  r_prod_ready <= 1'b1;
               end
            end
            ST_SEND: begin
               // byte_valid is always high here, so ready alone is a transfer.
               if (bus.byte_ready) begin
                  if (r_idx == c_LAST_IDX) begin
                     r_state      <= ST_IDLE;
                     r_idx        <= 3'd0;
                     r_prod_ready <= 1'b1;
                     r_byte_valid <= 1'b0;
                     r_byte_out   <= 8'h00;
                     r_byte_last  <= 1'b0;
                     r_frame_cnt  <= r_frame_cnt + 8'd1;
                  end else begin
                     r_idx        <= w_idx_nxt;
                     r_byte_out   <= f_pick(r_word, w_idx_nxt, w_class);
                     r_byte_last  <= (w_idx_nxt == c_LAST_IDX);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.prod_ready = r_prod_ready;
   assign bus.byte_out   = r_byte_out;
   assign bus.byte_valid = r_byte_valid;
   assign bus.byte_last  = r_byte_last;
   assign bus.busy       = (r_state == ST_SEND);
   assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp32_result_serializer.sv
`default_nettype none
// =============================================================================
// Module      : tb_fp32_result_serializer
// Description : Self-checking bench for fp32_result_serializer. Two DUTs
//               (MSB-first and LSB-first) share the same stimulus; a
//               queue-based frame model predicts every output each cycle.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fp32_result_serializer;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   fp32_result_serializer_if bus_m ();
   fp32_result_serializer_if bus_l ();

   fp32_result_serializer #(.MSB_FIRST(1)) u_dut_m (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_m)
   );

   fp32_result_serializer #(.MSB_FIRST(0)) u_dut_l (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_l)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: bytes still owed for the current frame, per byte order.
   logic [7:0] q_m[$];
   logic [7:0] q_l[$];
   bit         m_ready = 1'b0;
   int         m_cnt   = 0;
   int         m_frames = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] class_of(input logic [31:0] w);
      int e, m, s, c;
      e = int'((w >> 23) & 32'hFF);
      m = int'(w & 32'h7FFFFF);
      s = int'(w >> 31);
      c = 0;
      if (e == 0   && m == 0) c += 1;
      if (e == 255 && m == 0) c += 2;
      if (e == 255 && m != 0) c += 4;
      if (e == 0   && m != 0) c += 8;
      c += 16 * s;
      return 8'(c);
   endfunction

   task automatic model_capture(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) q_m.push_back(8'((w >> (8 * i)) & 32'hFF));
      for (int i = 0; i <= 3; i++) q_l.push_back(8'((w >> (8 * i)) & 32'hFF));
`ifdef FP32_SER_CLASS_EN
      q_m.push_back(class_of(w));
      q_l.push_back(class_of(w));
`endif
   endtask

   task automatic model_edge(input bit pv, input logic [31:0] pw, input bit br);
      if (q_m.size() != 0) begin
         if (br) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
            if (q_m.size() == 0) begin
               m_cnt = (m_cnt + 1) % 256;
               m_frames++;
               m_ready = 1'b1;
            end
         end
      end else if (m_ready && pv) begin
         model_capture(pw);
         m_ready = 1'b0;
      end else begin
         m_ready = 1'b1;
      end
   endtask

   task automatic model_reset();
      q_m.delete();
      q_l.delete();
      m_ready = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic check_all();
      bit busy;
      busy = (q_m.size() != 0);
      chk("m.prod_ready", 32'(bus_m.prod_ready), 32'(m_ready));
      chk("m.busy",       32'(bus_m.busy),       32'(busy));
      chk("m.byte_valid", 32'(bus_m.byte_valid), 32'(busy));
      chk("m.byte_out",   32'(bus_m.byte_out),   busy ? 32'(q_m[0]) : 32'd0);
      chk("m.byte_last",  32'(bus_m.byte_last),  32'(q_m.size() == 1));
      chk("m.frame_cnt",  32'(bus_m.frame_cnt),  32'(m_cnt));
      chk("l.prod_ready", 32'(bus_l.prod_ready), 32'(m_ready));
      chk("l.busy",       32'(bus_l.busy),       32'(busy));
      chk("l.byte_valid", 32'(bus_l.byte_valid), 32'(busy));
      chk("l.byte_out",   32'(bus_l.byte_out),   busy ? 32'(q_l[0]) : 32'd0);
      chk("l.byte_last",  32'(bus_l.byte_last),  32'(q_l.size() == 1));
      chk("l.frame_cnt",  32'(bus_l.frame_cnt),  32'(m_cnt));
   endtask

   task automatic drive(input bit pv, input logic [31:0] pw, input bit br);
      bus_m.prod_valid = pv;  bus_l.prod_valid = pv;
      bus_m.product    = pw;  bus_l.product    = pw;
      bus_m.byte_ready = br;  bus_l.byte_ready = br;
   endtask

   // One clock: drive inputs, let both DUT and model take the edge, check.
   task automatic cycle(input bit pv, input logic [31:0] pw, input bit br);
      drive(pv, pw, br);
      @(posedge clk);
      model_edge(pv, pw, br);
      @(negedge clk);
      check_all();
   endtask

   // Empty the current frame with byte_ready high, bounded.
   task automatic drain();
      int guard;
      guard = 0;
      while (q_m.size() != 0 && guard < 20) begin
         cycle(1'b0, $urandom, 1'b1);
         guard++;
      end
      chk("drain_timeout", 32'(q_m.size()), 32'd0);
      cycle(1'b0, 32'd0, 1'b1);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] specials [7];
      specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                   32'h7FC00000, 32'h00000001, 32'h807FFFFF};
      if ($urandom_range(3) == 0) return specials[$urandom_range(6)];
      return $urandom;
   endfunction

   initial begin
      int          guard;
      int          start_cnt;
      int          start_frames;
      logic [31:0] w;

      drive(1'b0, 32'd0, 1'b0);
      #1 reset = 1'b0;
      #2 check_all();
      @(negedge clk);
      check_all();
      reset = 1'b1;

      // Idle cycles after release: ready rises on the first edge.
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);

      // Pi with byte_ready held high.
      cycle(1'b1, 32'h40490FDB, 1'b1);
      drain();

      // 1.0 with a three-cycle stall on the third byte; garbage on product.
      cycle(1'b1, 32'h3F800000, 1'b1);
      cycle(1'b1, 32'hDEADBEEF, 1'b1);
      cycle(1'b1, 32'h12345678, 1'b1);
      cycle(1'b1, 32'hCAFEF00D, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      drain();

      // NaN then negative zero (class bytes when enabled).
      cycle(1'b1, 32'h7FC00000, 1'b1);
      drain();
      cycle(1'b1, 32'h80000000, 1'b1);
      drain();

      // Asynchronous reset two bytes into a frame.
      cycle(1'b1, 32'hC0000000, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      #2 reset = 1'b0;
      model_reset();
      #1 check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b1;
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h00000001, 1'b1);
      drain();
      chk("post_reset_cnt", 32'(bus_m.frame_cnt), 32'd1);

      // 256 back-to-back frames with prod_valid held high.
      start_cnt    = m_cnt;
      start_frames = m_frames;
      guard        = 0;
      while (m_frames - start_frames < 256 && guard < 3000) begin
         cycle(1'b1, rand_word(), 1'b1);
         guard++;
      end
      chk("b2b_frames", 32'(m_frames - start_frames), 32'd256);
      chk("b2b_wrap",   32'(bus_m.frame_cnt), 32'(start_cnt));
      drive(1'b0, 32'd0, 1'b1);
      drain();

      // Random traffic with random backpressure.
      for (int i = 0; i < 500; i++) begin
         w = rand_word();
         cycle($urandom_range(1) == 1, w, $urandom_range(9) < 7);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp32_result_serializer.md
FP32_RESULT_SERIALIZER -- requirements
Module: fp32_result_serializer

Interface
REQ-001 SHALL have parameter: MSB_FIRST, default 1, 1 = send product[31:24] first, 0 = send product[7:0] first.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: prod_valid  input  1  product word offered by the multiplier stage.
REQ-005 SHALL have port: product  input  32  IEEE-754 single-precision product.
REQ-006 SHALL have port: prod_ready  output  1  serializer can accept a word.
REQ-007 SHALL have port: byte_out  output  8  current output byte.
REQ-008 SHALL have port: byte_valid  output  1  byte_out holds a valid byte.
REQ-009 SHALL have port: byte_ready  input  1  downstream accepts byte_out.
REQ-010 SHALL have port: byte_last  output  1  current byte is the final byte of the frame.
REQ-011 SHALL have port: busy  output  1  frame in progress.
REQ-012 SHALL have port: frame_cnt  output  8  count of completed frames.

Function
REQ-013 SHALL implement an FSM with states IDLE and SEND, plus a byte index counter.
REQ-014 SHALL drive prod_ready = 1 only in IDLE.
REQ-015 Capture: when prod_valid && prod_ready at a clock edge, SHALL latch product into an internal word register, clear the index, and enter SEND.
REQ-016 In SEND, SHALL drive byte_valid = 1 and byte_out = the byte selected by the index and MSB_FIRST; first byte_valid appears the cycle after capture.
REQ-017 Transfer: a byte SHALL move only on byte_valid && byte_ready; the index then increments.
REQ-018 While byte_valid && !byte_ready, byte_out, byte_last and the index SHALL hold stable.
REQ-019 byte_last SHALL be 1 only while the final frame byte is presented (index 3, or index 4 with REQ-029).
REQ-020 On transfer of the last byte, SHALL return to IDLE and increment frame_cnt modulo 256 (255 -> 0).
REQ-021 No back-to-back capture: prod_ready SHALL rise the cycle after the last-byte transfer (one bubble cycle).
REQ-022 prod_valid and product SHALL be ignored outside IDLE; the latched word SHALL NOT change mid-frame.
REQ-023 busy SHALL equal (state == SEND).
REQ-024 In IDLE, byte_valid and byte_last SHALL be 0; byte_out SHALL be 8'h00.

Reset
REQ-025 reset low SHALL immediately force IDLE, index 0, word register 0, frame_cnt 0.
REQ-026 During reset: prod_ready = 0, byte_valid = 0, byte_last = 0, byte_out = 0, busy = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without incrementing frame_cnt; the aborted word SHALL NOT be resent.
REQ-028 prod_ready SHALL be 1 from the first clock edge after reset release.

Configuration
REQ-029 With FP32_SER_CLASS_EN defined, each frame SHALL have 5 bytes. The 5th byte, sent last regardless of MSB_FIRST, SHALL be the class byte computed from the latched word: bit0 zero (exp=0, mant=0); bit1 inf (exp=FF, mant=0); bit2 NaN (exp=FF, mant!=0); bit3 denormal (exp=0, mant!=0); bit4 sign; bits7:5 = 0.
REQ-030 Without FP32_SER_CLASS_EN, frames SHALL have 4 bytes and no class logic SHALL be synthesized.

Verification
REQ-031 MSB_FIRST=1, product=32'h40490FDB, byte_ready=1 -> bytes 40,49,0F,DB on consecutive cycles; byte_last on DB; frame_cnt 0 -> 1.
REQ-032 MSB_FIRST=0, product=32'h3F800000, byte_ready low 3 cycles on byte 2 -> bytes 00,00,80,3F; byte 80 held stable during the stall; prod_ready low until 1 cycle after 3F.
REQ-033 FP32_SER_CLASS_EN, product=32'h7FC00000 then 32'h80000000 -> class bytes 8'h04 and 8'h11; byte_last on the 5th byte.
REQ-034 Reset pulsed low after 2 bytes of 32'hC0000000 -> all outputs 0 immediately; frame_cnt 0; after release, a new word 32'h00000001 is sent cleanly.
REQ-035 256 back-to-back frames with prod_valid held high -> frame_cnt wraps to 0; exactly one bubble cycle between frames.
